// File: rtl/dahua_tx_pkg.sv
// Shared defaults, state encoding and counter sizing helpers for the dahua_tx
// parallel-video transmitter.
package dahua_tx_pkg;

  localparam int WIDTH_DEF     = 640;
  localparam int HEIGTH_DEF    = 480;
  localparam int DATA_W_DEF    = 8;
  localparam int H_BLANK_DEF   = 16;
  localparam int V_BLANK_DEF   = 32;
  localparam int FV_LV_DLY_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FV_PRE  = 3'd1,
    ACTIVE  = 3'd2,
    HBLANK  = 3'd3,
    FV_POST = 3'd4,
    VBLANK  = 3'd5
  } tx_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dahua_tx.sv
// AXI4-Stream video to camera-style parallel bus (D_OUT qualified by FV/LV).
// Line timing is free-running once a frame starts; missing pixels go out as 0.
module dahua_tx
  import dahua_tx_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int HEIGTH    = HEIGTH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int H_BLANK   = H_BLANK_DEF,
  parameter int V_BLANK   = V_BLANK_DEF,
  parameter int FV_LV_DLY = FV_LV_DLY_DEF
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] D_OUT,
  output logic              FV,
  output logic              LV,
  output logic              frame_done,
  output logic              underflow,
  output logic              len_err
);

  localparam int CW = cnt_w(WIDTH);
  localparam int RW = cnt_w(HEIGTH);
  localparam int BW = cnt_w(max3(H_BLANK, V_BLANK, FV_LV_DLY));

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGTH - 1);
  localparam logic [BW-1:0] DLY_LAST = BW'(FV_LV_DLY - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'(V_BLANK - 1);

  tx_state_t         r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [BW-1:0]     r_bcnt;
  logic [DATA_W-1:0] r_d_out;
  logic              r_fv;
  logic              r_lv;
  logic              r_frame_done;
  logic              r_underflow;
  logic              r_len_err;

  logic w_ready;
  logic w_active;
  logic w_beat;
  logic w_fv_nxt;
  logic w_len_bad;

  // IDLE swallows non-SOF beats; ACTIVE takes one beat per cycle regardless.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:    w_ready = s_axis_tvalid && !s_axis_tuser;
      ACTIVE:  w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_active  = (r_state == ACTIVE);
  assign w_beat    = w_active && s_axis_tvalid;
  assign w_fv_nxt  = !((r_state == IDLE) || (r_state == VBLANK));
  assign w_len_bad = (s_axis_tlast != (r_col == COL_LAST)) ||
                     (s_axis_tuser != ((r_col == {CW{1'b0}}) && (r_row == {RW{1'b0}})));

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_col        <= {CW{1'b0}};
      r_row        <= {RW{1'b0}};
      r_bcnt       <= {BW{1'b0}};
      r_d_out      <= {DATA_W{1'b0}};
      r_fv         <= 1'b0;
      r_lv         <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_fv         <= w_fv_nxt;
      r_lv         <= w_active;
      r_d_out      <= w_beat ? s_axis_tdata : {DATA_W{1'b0}};
      r_frame_done <= r_fv && !w_fv_nxt;
      if (w_active && !s_axis_tvalid) r_underflow <= 1'b1;
      if (w_beat && w_len_bad)        r_len_err   <= 1'b1;

      case (r_state)
        IDLE: begin
          // The SOF beat stays on the bus; ACTIVE consumes it as column 0.
          if (s_axis_tvalid && s_axis_tuser) begin
            r_state <= FV_PRE;
            r_bcnt  <= {BW{1'b0}};
            r_col   <= {CW{1'b0}};
            r_row   <= {RW{1'b0}};
          end
        end
        FV_PRE: begin
          if (r_bcnt == DLY_LAST) begin
            r_state <= ACTIVE;
            r_bcnt  <= {BW{1'b0}};
            r_col   <= {CW{1'b0}};
          end else begin
            r_bcnt  <= r_bcnt + BW'(1);
          end
        end
        ACTIVE: begin
          if (r_col == COL_LAST) begin
            r_state <= (r_row == ROW_LAST) ? FV_POST : HBLANK;
            r_col   <= {CW{1'b0}};
            r_bcnt  <= {BW{1'b0}};
          end else begin
            r_col   <= r_col + CW'(1);
          end
        end
        HBLANK: begin
          if (r_bcnt == HB_LAST) begin
            r_state <= ACTIVE;
            r_bcnt  <= {BW{1'b0}};
            r_col   <= {CW{1'b0}};
            r_row   <= r_row + RW'(1);
          end else begin
            r_bcnt  <= r_bcnt + BW'(1);
          end
        end
        FV_POST: begin
          if (r_bcnt == DLY_LAST) begin
            r_state <= VBLANK;
            r_bcnt  <= {BW{1'b0}};
          end else begin
            r_bcnt  <= r_bcnt + BW'(1);
          end
        end
        VBLANK: begin
          if (r_bcnt == VB_LAST) begin
            r_state <= IDLE;
            r_bcnt  <= {BW{1'b0}};
            r_row   <= {RW{1'b0}};
          end else begin
            r_bcnt  <= r_bcnt + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_bcnt  <= {BW{1'b0}};
          r_col   <= {CW{1'b0}};
          r_row   <= {RW{1'b0}};
        end
      endcase
    end
  end

  assign s_axis_tready = w_ready;
  assign D_OUT         = r_d_out;
  assign FV            = r_fv;
  assign LV            = r_lv;
  assign frame_done    = r_frame_done;
  assign underflow     = r_underflow;
  assign len_err       = r_len_err;

endmodule
